// File: rtl/insn_fetch_ctrl.sv
// insn_fetch_ctrl: owns the fetch PC, indexes insn_mem and feeds decode through a
// 2-entry skid buffer with valid/ready. Handles redirects, ECALL halt and misaligned-target fault.
// Optional build macro: FETCH_PERF_EN adds push and stall performance counters.
module insn_fetch_ctrl #(
   parameter int unsigned ADDR_W    = 10,
   parameter int unsigned RESET_IDX = 0
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   output logic [ADDR_W-1:0] o_mem_idx,
   input  logic [31:0]       i_mem_insn,
   input  logic              i_redirect_valid,
   input  logic [31:0]       i_redirect_target,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [31:0]       o_out_insn,
   output logic [31:0]       o_out_pc,
   output logic              o_halted,
   output logic              o_fault
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]       o_perf_fetch_cnt,
   output logic [31:0]       o_perf_stall_cnt
`endif
);

   localparam int unsigned DEPTH = 2;
   localparam logic [31:0] ECALL = 32'h0000_0073;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_HALT  = 2'd2,
      S_FAULT = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic              r_halted;
   logic              r_fault;
   logic              r_valid;
   logic [ADDR_W-1:0] r_idx;
   logic [ADDR_W-1:0] w_idx_next;
   logic [ADDR_W-1:0] r_buf_idx  [DEPTH];
   logic [31:0]       r_buf_insn [DEPTH];
   logic              r_head;
   logic [1:0]        r_count;
   logic [1:0]        w_count_next;
   logic              w_tail;
   logic              w_push;
   logic              w_pop;
   logic              w_flush;
   logic              w_misalign;
   logic [ADDR_W-1:0] w_target_idx;
   logic              w_unused_tgt;

   assign w_misalign   = |i_redirect_target[1:0];
   assign w_target_idx = i_redirect_target[ADDR_W+1:2];
   assign w_unused_tgt = ^i_redirect_target[31:ADDR_W+2];
   assign w_pop        = (r_count != 2'd0) && i_out_ready;
   assign w_tail       = r_head ^ r_count[0];

   // State register plus registered status flags derived from the next state
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= S_IDLE;
         r_halted <= 1'b0;
         r_fault  <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_halted <= (w_state_next == S_HALT);
         r_fault  <= (w_state_next == S_FAULT);
      end
   end

   // Next state, PC update and push/flush decisions; a redirect always beats fetch
   always_comb begin
      w_state_next = r_state;
      w_idx_next   = r_idx;
      w_push       = 1'b0;
      w_flush      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_redirect_valid && !w_misalign) begin
               w_idx_next = w_target_idx;
            end
            if (i_start) begin
               w_state_next = S_RUN;
            end
         end
         S_RUN, S_HALT: begin
            if (i_redirect_valid) begin
               w_flush = 1'b1;
               if (w_misalign) begin
                  w_state_next = S_FAULT;
               end else begin
                  w_idx_next   = w_target_idx;
                  w_state_next = S_RUN;
               end
            end else if ((r_state == S_RUN) && ((r_count < 2'd2) || w_pop)) begin
               w_push     = 1'b1;
               w_idx_next = r_idx + ADDR_W'(1);
               if (i_mem_insn == ECALL) begin
                  w_state_next = S_HALT;
               end
            end
         end
         S_FAULT: begin
            w_flush = 1'b1;
         end
         default: begin
            w_state_next = S_IDLE;
            w_flush      = 1'b1;
         end
      endcase
   end

   // Buffer occupancy after this cycle's push/pop, or empty on a flush
   always_comb begin
      w_count_next = r_count;
      if (w_flush) begin
         w_count_next = 2'd0;
      end else begin
         w_count_next = r_count + 2'(w_push) - 2'(w_pop);
      end
   end

   // Program counter
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_idx <= ADDR_W'(RESET_IDX);
      end else begin
         r_idx <= w_idx_next;
      end
   end

   // Skid buffer storage, head pointer and occupancy; push lands at the tail slot
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_buf_idx[i]  <= '0;
            r_buf_insn[i] <= '0;
         end
         r_head  <= 1'b0;
         r_count <= 2'd0;
         r_valid <= 1'b0;
      end else begin
         r_count <= w_count_next;
         r_valid <= (w_count_next != 2'd0);
         if (w_flush) begin
            r_head <= 1'b0;
         end else begin
            if (w_push) begin
               r_buf_idx[w_tail]  <= r_idx;
               r_buf_insn[w_tail] <= i_mem_insn;
            end
            if (w_pop) begin
               r_head <= ~r_head;
            end
         end
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] r_perf_fetch_cnt;
   logic [31:0] r_perf_stall_cnt;

   // Push counter and full-without-pop stall counter, both free-running and wrapping
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_perf_fetch_cnt <= '0;
         r_perf_stall_cnt <= '0;
      end else begin
         if (w_push) begin
            r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
         end
         if ((r_state == S_RUN) && (r_count == 2'd2) && !w_pop) begin
            r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
         end
      end
   end

   assign o_perf_fetch_cnt = r_perf_fetch_cnt;
   assign o_perf_stall_cnt = r_perf_stall_cnt;
`endif

   assign o_mem_idx   = r_idx;
   assign o_out_valid = r_valid;
   assign o_out_insn  = r_buf_insn[r_head];
   assign o_out_pc    = 32'({r_buf_idx[r_head], 2'b00});
   assign o_halted    = r_halted;
   assign o_fault     = r_fault;

endmodule

// File: tb/tb_insn_fetch_ctrl.sv
// Testbench for insn_fetch_ctrl: directed scenarios plus randomized traffic against a
// queue-based fetch model. A second instance with RESET_IDX=1023 covers PC wrap.
`timescale 1ns/1ps
module tb_insn_fetch_ctrl;

   localparam logic [31:0] ECALL = 32'h0000_0073;
   localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2, M_FAULT = 3;

   logic        clk = 1'b0;
   logic        rst, start, redirect_valid, out_ready;
   logic [31:0] redirect_target;
   logic [9:0]  mem_idx, mem_idx2;
   logic [31:0] mem_insn, mem_insn2;
   logic        out_valid, out_valid2, halted, halted2, fault, fault2;
   logic [31:0] out_insn, out_insn2, out_pc, out_pc2;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetch, perf_stall, perf_fetch2, perf_stall2;
`endif

   logic [31:0] mem [1024];
   assign mem_insn  = mem[mem_idx];
   assign mem_insn2 = mem[mem_idx2];

   always #5 clk = ~clk;

   insn_fetch_ctrl #(.ADDR_W(10), .RESET_IDX(0)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .o_mem_idx(mem_idx), .i_mem_insn(mem_insn),
      .i_redirect_valid(redirect_valid), .i_redirect_target(redirect_target),
      .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_insn(out_insn), .o_out_pc(out_pc),
      .o_halted(halted), .o_fault(fault)
`ifdef FETCH_PERF_EN
      , .o_perf_fetch_cnt(perf_fetch), .o_perf_stall_cnt(perf_stall)
`endif
   );

   insn_fetch_ctrl #(.ADDR_W(10), .RESET_IDX(1023)) dut_wrap (
      .i_clk(clk), .i_rst(rst), .i_start(start), .o_mem_idx(mem_idx2), .i_mem_insn(mem_insn2),
      .i_redirect_valid(redirect_valid), .i_redirect_target(redirect_target),
      .o_out_valid(out_valid2), .i_out_ready(out_ready), .o_out_insn(out_insn2), .o_out_pc(out_pc2),
      .o_halted(halted2), .o_fault(fault2)
`ifdef FETCH_PERF_EN
      , .o_perf_fetch_cnt(perf_fetch2), .o_perf_stall_cnt(perf_stall2)
`endif
   );

   int          checks = 0;
   int          errors = 0;

   // Reference model: state name, PC word index, and an ordered queue of buffered fetches
   int          m_state;
   int          m_idx;
   logic [31:0] q_pc[$];
   logic [31:0] q_insn[$];
   int unsigned m_fetch, m_stall;

   function automatic logic [31:0] rand_insn();
      logic [31:0] v;
      v = $urandom();
      if (v == ECALL) v = 32'h0000_0013;
      return v;
   endfunction

   task automatic fill_mem();
      for (int i = 0; i < 1024; i++) mem[i] = rand_insn();
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; redirect_valid = 1'b0; redirect_target = '0; out_ready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      m_state = M_IDLE; m_idx = 0; q_pc.delete(); q_insn.delete(); m_fetch = 0; m_stall = 0;
   endtask

   // Drive one cycle of inputs and advance the model by the fetch rules
   task automatic step(input logic st, input logic rv, input logic [31:0] tgt, input logic rdy);
      int n;
      bit pop;
      start = st; redirect_valid = rv; redirect_target = tgt; out_ready = rdy;
      n   = q_pc.size();
      pop = (n > 0) && rdy;
      if (m_state == M_RUN && n == 2 && !pop) m_stall++;
      case (m_state)
         M_IDLE: begin
            if (rv && tgt[1:0] == 2'b00) m_idx = int'(tgt[11:2]);
            if (st) m_state = M_RUN;
         end
         M_RUN, M_HALT: begin
            if (rv) begin
               q_pc.delete(); q_insn.delete();
               if (tgt[1:0] != 2'b00) m_state = M_FAULT;
               else begin m_idx = int'(tgt[11:2]); m_state = M_RUN; end
            end else begin
               if (pop) begin void'(q_pc.pop_front()); void'(q_insn.pop_front()); end
               if (m_state == M_RUN && (n < 2 || pop)) begin
                  q_pc.push_back(32'(m_idx * 4));
                  q_insn.push_back(mem[m_idx]);
                  m_fetch++;
                  if (mem[m_idx] == ECALL) m_state = M_HALT;
                  m_idx = (m_idx + 1) % 1024;
               end
            end
         end
         default: begin end
      endcase
      @(posedge clk); #1;
      start = 1'b0; redirect_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (mem_idx !== 10'd0) begin errors++; $display("FAIL reset_mem_idx got %0d want 0", mem_idx); end
      checks++; if (mem_idx2 !== 10'd1023) begin errors++; $display("FAIL reset_mem_idx_wrap got %0d want 1023", mem_idx2); end
      checks++; if ({out_valid, halted, fault} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {out_valid, halted, fault}); end
      checks++; if ({out_insn, out_pc} !== 64'd0) begin errors++; $display("FAIL reset_data got %h %h want 0 0", out_insn, out_pc); end
`ifdef FETCH_PERF_EN
      checks++; if ({perf_fetch, perf_stall} !== 64'd0) begin errors++; $display("FAIL reset_perf got %0d %0d want 0 0", perf_fetch, perf_stall); end
`endif
   endtask

   task automatic test_stream();
      do_reset();
      mem[0] = 32'h0031_00b3; mem[1] = 32'h4031_00b3; mem[2] = 32'h0031_70b3;
      step(1'b1, 1'b0, 32'd0, 1'b1);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_first_valid got %b want 0", out_valid); end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 32'd0, 1'b1);
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %b want 1", i, out_valid); end
         checks++; if (out_pc !== 32'(i * 4)) begin errors++; $display("FAIL stream_pc[%0d] got %h want %h", i, out_pc, i * 4); end
         checks++; if (out_insn !== mem[i]) begin errors++; $display("FAIL stream_insn[%0d] got %h want %h", i, out_insn, mem[i]); end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] held;
      do_reset();
      step(1'b1, 1'b0, 32'd0, 1'b0);
      step(1'b0, 1'b0, 32'd0, 1'b0);
      held = out_insn;
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 32'd0, 1'b0);
         checks++; if (out_valid !== 1'b1 || out_pc !== 32'd0 || out_insn !== held) begin
            errors++; $display("FAIL hold[%0d] got v%b pc %h insn %h want v1 pc 0 insn %h", i, out_valid, out_pc, out_insn, held);
         end
      end
      checks++; if (held !== mem[0]) begin errors++; $display("FAIL hold_insn got %h want %h", held, mem[0]); end
      checks++; if (mem_idx !== 10'd2) begin errors++; $display("FAIL hold_mem_idx got %0d want 2", mem_idx); end
`ifdef FETCH_PERF_EN
      checks++; if (perf_stall !== 32'd3) begin errors++; $display("FAIL hold_stall_cnt got %0d want 3", perf_stall); end
      checks++; if (perf_fetch !== 32'd2) begin errors++; $display("FAIL hold_fetch_cnt got %0d want 2", perf_fetch); end
`endif
   endtask

   // Runs straight after test_backpressure, with the buffer still full
   task automatic test_redirect();
      step(1'b0, 1'b1, 32'h0000_0030, 1'b1);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_flush_valid got %b want 0", out_valid); end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 32'd0, 1'b1);
         checks++; if (out_valid !== 1'b1 || out_pc !== 32'(32'h30 + i * 4)) begin
            errors++; $display("FAIL redir_pc[%0d] got v%b %h want v1 %h", i, out_valid, out_pc, 32'h30 + i * 4);
         end
         checks++; if (out_insn !== mem[12 + i]) begin errors++; $display("FAIL redir_insn[%0d] got %h want %h", i, out_insn, mem[12 + i]); end
      end
   endtask

   task automatic test_ecall();
      logic [31:0] want_pc [3];
      want_pc[0] = 32'h0; want_pc[1] = 32'h4; want_pc[2] = 32'h8;
      do_reset();
      mem[2] = ECALL;
      step(1'b1, 1'b0, 32'd0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 32'd0, 1'b1);
         checks++; if (out_valid !== 1'b1 || out_pc !== want_pc[i]) begin
            errors++; $display("FAIL ecall_drain_pc[%0d] got v%b %h want v1 %h", i, out_valid, out_pc, want_pc[i]);
         end
      end
      checks++; if (halted !== 1'b1 || out_insn !== ECALL) begin errors++; $display("FAIL ecall_halt got h%b insn %h want h1 insn %h", halted, out_insn, ECALL); end
      step(1'b0, 1'b0, 32'd0, 1'b1);
      step(1'b0, 1'b0, 32'd0, 1'b1);
      checks++; if (mem_idx !== 10'd3 || out_valid !== 1'b0 || halted !== 1'b1) begin
         errors++; $display("FAIL ecall_stop got idx %0d v%b h%b want idx 3 v0 h1", mem_idx, out_valid, halted);
      end
      mem[2] = rand_insn();
      step(1'b0, 1'b1, 32'd0, 1'b1);
      checks++; if (halted !== 1'b0 || mem_idx !== 10'd0) begin errors++; $display("FAIL ecall_resume got h%b idx %0d want h0 idx 0", halted, mem_idx); end
      step(1'b0, 1'b0, 32'd0, 1'b1);
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'd0) begin errors++; $display("FAIL ecall_resume_pc got v%b %h want v1 0", out_valid, out_pc); end
   endtask

   task automatic test_random();
      logic st, rv, rdy;
      logic [31:0] tgt;
      do_reset();
      for (int i = 0; i < 12; i++) mem[$urandom_range(1023, 0)] = ECALL;
      step(1'b1, 1'b0, 32'd0, 1'b1);
      for (int c = 0; c < 800; c++) begin
         st  = ($urandom_range(15, 0) == 0);
         rv  = ($urandom_range(7, 0) == 0);
         tgt = $urandom() & 32'hFFFF_FFFC;
         rdy = ($urandom_range(3, 0) != 0);
         step(st, rv, tgt, rdy);
         checks++; if (out_valid !== (q_pc.size() > 0)) begin errors++; $display("FAIL rand_valid c%0d got %b want %b", c, out_valid, q_pc.size() > 0); end
         if (q_pc.size() > 0) begin
            checks++; if (out_pc !== q_pc[0] || out_insn !== q_insn[0]) begin
               errors++; $display("FAIL rand_head c%0d got %h/%h want %h/%h", c, out_pc, out_insn, q_pc[0], q_insn[0]);
            end
         end
         checks++; if (int'(mem_idx) != m_idx) begin errors++; $display("FAIL rand_mem_idx c%0d got %0d want %0d", c, mem_idx, m_idx); end
         checks++; if (halted !== (m_state == M_HALT) || fault !== 1'b0) begin
            errors++; $display("FAIL rand_status c%0d got h%b f%b want h%b f0", c, halted, fault, m_state == M_HALT);
         end
      end
`ifdef FETCH_PERF_EN
      checks++; if (perf_fetch !== 32'(m_fetch) || perf_stall !== 32'(m_stall)) begin
         errors++; $display("FAIL rand_perf got %0d/%0d want %0d/%0d", perf_fetch, perf_stall, m_fetch, m_stall);
      end
`endif
      fill_mem();
   endtask

   task automatic test_fault();
      logic [9:0] idx_before;
      do_reset();
      step(1'b1, 1'b0, 32'd0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0, 1'b0);
      idx_before = mem_idx;
      checks++; if (int'(idx_before) != m_idx) begin errors++; $display("FAIL fault_pre_idx got %0d want %0d", idx_before, m_idx); end
      step(1'b0, 1'b1, 32'h0000_0022, 1'b1);
      checks++; if (fault !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL fault_set got f%b v%b want f1 v0", fault, out_valid); end
      checks++; if (mem_idx !== idx_before) begin errors++; $display("FAIL fault_idx got %0d want %0d", mem_idx, idx_before); end
      step(1'b1, 1'b1, 32'h0000_0040, 1'b1);
      step(1'b0, 1'b0, 32'd0, 1'b1);
      step(1'b0, 1'b0, 32'd0, 1'b1);
      checks++; if (fault !== 1'b1 || out_valid !== 1'b0 || mem_idx !== idx_before) begin
         errors++; $display("FAIL fault_sticky got f%b v%b idx %0d want f1 v0 idx %0d", fault, out_valid, mem_idx, idx_before);
      end
      do_reset();
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL fault_clear got %b want 0", fault); end
   endtask

   task automatic test_wrap_and_mid_reset();
      do_reset();
      step(1'b1, 1'b0, 32'd0, 1'b1);
      checks++; if (out_valid2 !== 1'b0) begin errors++; $display("FAIL wrap_first_valid got %b want 0", out_valid2); end
      step(1'b0, 1'b0, 32'd0, 1'b1);
      checks++; if (out_valid2 !== 1'b1 || out_pc2 !== 32'h0000_0FFC || out_insn2 !== mem[1023]) begin
         errors++; $display("FAIL wrap_pc_ffc got v%b %h/%h want v1 00000ffc/%h", out_valid2, out_pc2, out_insn2, mem[1023]);
      end
      checks++; if (mem_idx2 !== 10'd0) begin errors++; $display("FAIL wrap_idx got %0d want 0", mem_idx2); end
      step(1'b0, 1'b0, 32'd0, 1'b1);
      checks++; if (out_valid2 !== 1'b1 || out_pc2 !== 32'd0 || out_insn2 !== mem[0]) begin
         errors++; $display("FAIL wrap_pc_0 got v%b %h/%h want v1 0/%h", out_valid2, out_pc2, out_insn2, mem[0]);
      end
      step(1'b0, 1'b0, 32'd0, 1'b0);
      step(1'b0, 1'b0, 32'd0, 1'b0);
      rst = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; out_ready = 1'b0;
      checks++; if (mem_idx !== 10'd0 || mem_idx2 !== 10'd1023) begin errors++; $display("FAIL midrst_idx got %0d/%0d want 0/1023", mem_idx, mem_idx2); end
      checks++; if ({out_valid, out_valid2, halted, halted2, fault, fault2} !== 6'd0) begin
         errors++; $display("FAIL midrst_flags got %b want 000000", {out_valid, out_valid2, halted, halted2, fault, fault2});
      end
      checks++; if ({out_insn, out_pc, out_insn2, out_pc2} !== 128'd0) begin
         errors++; $display("FAIL midrst_data got %h %h %h %h want all 0", out_insn, out_pc, out_insn2, out_pc2);
      end
`ifdef FETCH_PERF_EN
      checks++; if ({perf_fetch, perf_stall} !== 64'd0) begin errors++; $display("FAIL midrst_perf got %0d %0d want 0 0", perf_fetch, perf_stall); end
`endif
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; redirect_valid = 1'b0; redirect_target = '0; out_ready = 1'b0;
      fill_mem();
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_ecall();
      test_random();
      test_fault();
      test_wrap_and_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
